// File: rtl/vector_pkg.sv
// Shared vector datapath definitions: opcode set common to the sequencer and
// the vector ALU, default datapath dimensions and the sequencer state type.
package vector_pkg;

   localparam int DEF_DATA_WIDTH = 10;
   localparam int DEF_OPER_WIDTH = 10;
   localparam int DEF_LANES      = 8;

   typedef enum logic [3:0] {
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5,
      OP_MV  = 4'd6,
      OP_ROL = 4'd7,
      OP_ROR = 4'd8
   } vec_op_e;

   // Sequencer state kept as plain constants so older tools can read it.
   typedef logic [0:0] seq_state_t;
   localparam seq_state_t ST_IDLE = 1'b0;
   localparam seq_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/vector_lane_mux.sv
// Combinational LANES:1 element selector over a packed operand vector.
// Element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
module vector_lane_mux #(
   parameter int DATA_WIDTH = 10,
   parameter int LANES      = 8,
   parameter int SEL_WIDTH  = 3
) (
   input  logic [LANES*DATA_WIDTH-1:0] vec,
   input  logic [SEL_WIDTH-1:0]        sel,
   output logic [DATA_WIDTH-1:0]       elem
);

   // Pick the element addressed by sel; out-of-range selects read as zero.
   always_comb begin
      elem = '0;
      for (int k = 0; k < LANES; k++) begin
         if (sel == SEL_WIDTH'(k)) begin
            elem = vec[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Vector operand sequencer: latches one packed vector command and issues its
// elements one per cycle as scalar operand pairs to the vector ALU, flagging
// the final element. Optional feature macro: VECTOR_SEQ_SCALAR_EN, which lets
// a command broadcast B element 0 as the second operand of every beat.
module vector_lane_sequencer
   import vector_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int OPER_WIDTH = DEF_OPER_WIDTH,
   parameter int LANES      = DEF_LANES,
   parameter int LEN_WIDTH  = $clog2(LANES+1)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [LANES*DATA_WIDTH-1:0] t_a,
   input  logic [LANES*DATA_WIDTH-1:0] t_b,
   input  logic [OPER_WIDTH-1:0]       t_oper,
   input  logic [LEN_WIDTH-1:0]        t_len,
   input  logic                        t_scalar,
   input  logic                        t_valid,
   output logic                        t_ready,
   output logic [DATA_WIDTH-1:0]       i0_data,
   output logic [DATA_WIDTH-1:0]       i1_data,
   output logic [OPER_WIDTH-1:0]       i_oper,
   output logic                        i_last,
   output logic                        i_valid,
   input  logic                        i_ready,
   output logic                        busy
);

   localparam int IDX_WIDTH = $clog2(LANES);

   seq_state_t                  state;
   logic [IDX_WIDTH-1:0]        idx;
   logic [IDX_WIDTH-1:0]        b_idx;
   logic [LEN_WIDTH-1:0]        len_q;
   logic [LEN_WIDTH-1:0]        len_clamped;
   logic [LANES*DATA_WIDTH-1:0] a_q;
   logic [LANES*DATA_WIDTH-1:0] b_q;
   logic [OPER_WIDTH-1:0]       oper_q;
   logic                        last_q;
   logic                        cmd_fire;
   logic                        beat_fire;

   // Commands longer than the vector are cut to the full vector.
   function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
      if (len > LEN_WIDTH'(LANES)) begin
         return LEN_WIDTH'(LANES);
      end
      return len;
   endfunction

   assign len_clamped = clamp_len(t_len);

   // A new command is taken when idle, or in the same cycle the last element
   // leaves so consecutive commands stream without a bubble. Held off in reset.
   assign t_ready   = rstn && ((state == ST_IDLE) || (last_q && i_ready));
   assign cmd_fire  = t_valid && t_ready;
   assign beat_fire = i_valid && i_ready;

   assign i_valid = (state == ST_RUN);
   assign busy    = (state == ST_RUN);
   assign i_last  = last_q;
   assign i_oper  = oper_q;

   // Command latch, element index and last-element flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= ST_IDLE;
         idx    <= '0;
         len_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         oper_q <= '0;
         last_q <= 1'b0;
      end else if (cmd_fire) begin
         if (len_clamped != '0) begin
            state  <= ST_RUN;
            idx    <= '0;
            len_q  <= len_clamped;
            a_q    <= t_a;
            b_q    <= t_b;
            oper_q <= t_oper;
            last_q <= (len_clamped == LEN_WIDTH'(1));
         end else begin
            // Zero-length command: accepted but nothing to issue.
            state  <= ST_IDLE;
            last_q <= 1'b0;
         end
      end else if (beat_fire) begin
         if (last_q) begin
            state  <= ST_IDLE;
            last_q <= 1'b0;
         end else begin
            idx    <= idx + IDX_WIDTH'(1);
            // Next index is the final one when idx + 1 == len - 1.
            last_q <= ((LEN_WIDTH'(idx) + LEN_WIDTH'(2)) == len_q);
         end
      end
   end

`ifdef VECTOR_SEQ_SCALAR_EN
   logic scalar_q;

   // Broadcast flag captured with each issuing command.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scalar_q <= 1'b0;
      end else if (cmd_fire && (len_clamped != '0)) begin
         scalar_q <= t_scalar;
      end
   end

   assign b_idx = scalar_q ? '0 : idx;
`else
   logic scalar_unused;
   assign scalar_unused = t_scalar;
   assign b_idx         = idx;
`endif

   vector_lane_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .SEL_WIDTH  (IDX_WIDTH)
   ) u_mux_a (
      .vec  (a_q),
      .sel  (idx),
      .elem (i0_data)
   );

   vector_lane_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .SEL_WIDTH  (IDX_WIDTH)
   ) u_mux_b (
      .vec  (b_q),
      .sel  (b_idx),
      .elem (i1_data)
   );

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Testbench for vector_lane_sequencer: directed scenarios plus a randomized
// run, all checked against a queue-based model of the expected beats.
module tb_vector_lane_sequencer;
   import vector_pkg::*;

   localparam int DW = 10;
   localparam int OW = 10;
   localparam int L  = 8;
   localparam int LW = $clog2(L+1);
`ifdef VECTOR_SEQ_SCALAR_EN
   localparam bit SCALAR_EN = 1'b1;
`else
   localparam bit SCALAR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [OW-1:0] oper;
      logic          last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [L*DW-1:0] t_a = '0;
   logic [L*DW-1:0] t_b = '0;
   logic [OW-1:0]   t_oper = '0;
   logic [LW-1:0]   t_len = '0;
   logic            t_scalar = 1'b0;
   logic            t_valid = 1'b0;
   logic            t_ready;
   logic [DW-1:0]   i0_data;
   logic [DW-1:0]   i1_data;
   logic [OW-1:0]   i_oper;
   logic            i_last;
   logic            i_valid;
   logic            i_ready = 1'b0;
   logic            busy;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   always #5 clk = ~clk;

   vector_lane_sequencer dut (
      .clk      (clk),
      .rstn     (rstn),
      .t_a      (t_a),
      .t_b      (t_b),
      .t_oper   (t_oper),
      .t_len    (t_len),
      .t_scalar (t_scalar),
      .t_valid  (t_valid),
      .t_ready  (t_ready),
      .i0_data  (i0_data),
      .i1_data  (i1_data),
      .i_oper   (i_oper),
      .i_last   (i_last),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .busy     (busy)
   );

   // Reference model: a command expands into min(len, L) beats.
   function automatic void model_cmd(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b,
                                     input logic [OW-1:0] op, input logic [LW-1:0] len,
                                     input logic sc);
      int    n;
      beat_t bt;
      n = (int'(len) > L) ? L : int'(len);
      for (int k = 0; k < n; k++) begin
         bt.a    = a[k*DW +: DW];
         bt.b    = (SCALAR_EN && sc) ? b[DW-1:0] : b[k*DW +: DW];
         bt.oper = op;
         bt.last = (k == n-1);
         exp_q.push_back(bt);
      end
   endfunction

   task automatic rand_vec(output logic [L*DW-1:0] v);
      for (int k = 0; k < L; k++) v[k*DW +: DW] = DW'($urandom);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({i_valid, i_last, busy, t_ready} !== 4'b0000)
         $display("FAIL reset_ctrl got v/l/busy/tr=%b want 0000", {i_valid, i_last, busy, t_ready});
      else n_pass++;
      n_checks++;
      if ({i0_data, i1_data, i_oper} !== '0)
         $display("FAIL reset_data got %h/%h/%h want 0/0/0", i0_data, i1_data, i_oper);
      else n_pass++;
      rstn = 1'b1;
      #1;
      n_checks++;
      if ({t_ready, i_valid} !== 2'b10)
         $display("FAIL reset_release got tr/v=%b want 10", {t_ready, i_valid});
      else n_pass++;
   endtask

   task automatic test_single();
      for (int k = 0; k < L; k++) begin
         t_a[k*DW +: DW] = DW'(k+1);
         t_b[k*DW +: DW] = DW'(2);
      end
      @(negedge clk);
      t_oper = OW'(OP_ADD); t_len = LW'(8); t_scalar = 1'b0; t_valid = 1'b1; i_ready = 1'b1;
      #1;
      n_checks++;
      if (t_ready !== 1'b1) $display("FAIL single_tready got %b want 1", t_ready);
      else n_pass++;
      @(negedge clk);
      t_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if ({i_valid, i_last, i0_data, i1_data, i_oper, busy} !==
             {1'b1, 1'(k == 7), DW'(k+1), DW'(2), OW'(1), 1'b1})
            $display("FAIL single_beat%0d got v=%b l=%b a=%0d b=%0d op=%0d busy=%b want v=1 l=%b a=%0d b=2 op=1 busy=1",
                     k, i_valid, i_last, i0_data, i1_data, i_oper, busy, (k == 7), k+1);
         else n_pass++;
         @(negedge clk);
      end
      n_checks++;
      if ({i_valid, busy} !== 2'b00) $display("FAIL single_end got v/busy=%b want 00", {i_valid, busy});
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [4:0] pat = 5'b11001;
      int hs = 0;
      exp_q.delete();
      @(negedge clk);
      rand_vec(t_a); rand_vec(t_b);
      t_oper = OW'($urandom); t_len = LW'(3); t_scalar = 1'b0; t_valid = 1'b1; i_ready = 1'b0;
      model_cmd(t_a, t_b, t_oper, t_len, t_scalar);
      @(negedge clk);
      t_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         i_ready = pat[c];
         #1;
         n_checks++;
         if (exp_q.size() == 0) $display("FAIL bp_model_empty cycle %0d", c);
         else if ({i_valid, i0_data, i1_data, i_oper, i_last} !== {1'b1, exp_q[0]})
            $display("FAIL bp_beat c%0d got v=%b %h/%h/%h/%b want v=1 %h/%h/%h/%b", c, i_valid,
                     i0_data, i1_data, i_oper, i_last, exp_q[0].a, exp_q[0].b, exp_q[0].oper, exp_q[0].last);
         else n_pass++;
         if (i_valid && i_ready) hs++;
         if (pat[c] && exp_q.size() != 0) void'(exp_q.pop_front());
         @(negedge clk);
      end
      i_ready = 1'b0;
      n_checks++;
      if (hs != 3 || i_valid !== 1'b0)
         $display("FAIL bp_count got handshakes=%0d v=%b want 3 v=0", hs, i_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [L*DW-1:0] a2, b2;
      logic [OW-1:0]   op2;
      exp_q.delete();
      @(negedge clk);
      rand_vec(t_a); rand_vec(t_b);
      t_oper = OW'($urandom); t_len = LW'(2); t_scalar = 1'b0; t_valid = 1'b1; i_ready = 1'b1;
      model_cmd(t_a, t_b, t_oper, t_len, t_scalar);
      @(negedge clk);
      rand_vec(a2); rand_vec(b2); op2 = OW'($urandom);
      t_a = a2; t_b = b2; t_oper = op2;
      model_cmd(a2, b2, op2, LW'(2), 1'b0);
      #1;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if ({i_valid, i0_data, i1_data, i_oper, i_last} !== {1'b1, exp_q[0]})
            $display("FAIL b2b_beat%0d got v=%b %h/%h/%h/%b want v=1 %h/%h/%h/%b", c, i_valid,
                     i0_data, i1_data, i_oper, i_last, exp_q[0].a, exp_q[0].b, exp_q[0].oper, exp_q[0].last);
         else n_pass++;
         n_checks++;
         if (t_ready !== 1'(c == 1 || c == 3))
            $display("FAIL b2b_tready%0d got %b want %b", c, t_ready, (c == 1 || c == 3));
         else n_pass++;
         void'(exp_q.pop_front());
         @(negedge clk);
         if (c == 1) t_valid = 1'b0;
         #1;
      end
      n_checks++;
      if ({i_valid, busy} !== 2'b00) $display("FAIL b2b_end got v/busy=%b want 00", {i_valid, busy});
      else n_pass++;
   endtask

   task automatic test_len_zero();
      @(negedge clk);
      rand_vec(t_a); rand_vec(t_b);
      t_len = '0; t_valid = 1'b1; i_ready = 1'b1;
      #1;
      n_checks++;
      if (t_ready !== 1'b1) $display("FAIL len0_accept got tr=%b want 1", t_ready);
      else n_pass++;
      @(negedge clk);
      t_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if ({i_valid, busy, t_ready} !== 3'b001)
            $display("FAIL len0_idle%0d got v/busy/tr=%b want 001", c, {i_valid, busy, t_ready});
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_len_clamp();
      int cnt = 0;
      exp_q.delete();
      @(negedge clk);
      rand_vec(t_a); rand_vec(t_b);
      t_oper = OW'($urandom); t_len = LW'(12); t_scalar = 1'b0; t_valid = 1'b1; i_ready = 1'b1;
      model_cmd(t_a, t_b, t_oper, t_len, t_scalar);
      @(negedge clk);
      t_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         n_checks++;
         if (exp_q.size() != 0) begin
            if ({i_valid, i0_data, i1_data, i_oper, i_last} !== {1'b1, exp_q[0]})
               $display("FAIL clamp_beat%0d got v=%b %h/%h/%h/%b want v=1 %h/%h/%h/%b", c, i_valid,
                        i0_data, i1_data, i_oper, i_last, exp_q[0].a, exp_q[0].b, exp_q[0].oper, exp_q[0].last);
            else n_pass++;
            void'(exp_q.pop_front());
         end else begin
            if (i_valid !== 1'b0) $display("FAIL clamp_extra%0d got v=%b want 0", c, i_valid);
            else n_pass++;
         end
         if (i_valid === 1'b1) cnt++;
         @(negedge clk);
      end
      n_checks++;
      if (cnt != 8) $display("FAIL clamp_count got %0d beats want 8", cnt);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      exp_q.delete();
      @(negedge clk);
      rand_vec(t_a); rand_vec(t_b);
      t_oper = OW'($urandom); t_len = LW'(8); t_scalar = 1'b0; t_valid = 1'b1; i_ready = 1'b1;
      @(negedge clk);
      t_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if ({i_valid, busy, t_ready} !== 3'b000)
         $display("FAIL rstmid_abort got v/busy/tr=%b want 000", {i_valid, busy, t_ready});
      else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      rand_vec(t_a); rand_vec(t_b);
      t_oper = OW'($urandom); t_len = LW'(1); t_valid = 1'b1;
      model_cmd(t_a, t_b, t_oper, t_len, t_scalar);
      @(negedge clk);
      t_valid = 1'b0;
      n_checks++;
      if ({i_valid, i0_data, i1_data, i_oper, i_last} !== {1'b1, exp_q[0]})
         $display("FAIL rstmid_beat got v=%b %h/%h/%h/%b want v=1 %h/%h/%h/%b", i_valid,
                  i0_data, i1_data, i_oper, i_last, exp_q[0].a, exp_q[0].b, exp_q[0].oper, exp_q[0].last);
      else n_pass++;
      void'(exp_q.pop_front());
      @(negedge clk);
      n_checks++;
      if (i_valid !== 1'b0) $display("FAIL rstmid_end got v=%b want 0", i_valid);
      else n_pass++;
   endtask

   task automatic test_scalar();
      exp_q.delete();
      @(negedge clk);
      rand_vec(t_a); rand_vec(t_b);
      t_b[DW-1:0] = DW'(5); t_b[2*DW-1:DW] = DW'(9);
      t_oper = OW'(OP_MV); t_len = LW'(4); t_scalar = 1'b1; t_valid = 1'b1; i_ready = 1'b1;
      model_cmd(t_a, t_b, t_oper, t_len, t_scalar);
      @(negedge clk);
      t_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if ({i_valid, i0_data, i1_data, i_oper, i_last} !== {1'b1, exp_q[0]})
            $display("FAIL scalar_beat%0d got v=%b %h/%h/%h/%b want v=1 %h/%h/%h/%b", c, i_valid,
                     i0_data, i1_data, i_oper, i_last, exp_q[0].a, exp_q[0].b, exp_q[0].oper, exp_q[0].last);
         else n_pass++;
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      t_scalar = 1'b0;
   endtask

   task automatic test_random();
      bit pending = 1'b0;
      bit exp_run, exp_tready;
      exp_q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         i_ready = ($urandom_range(0, 3) != 0);
         if (!pending) begin
            if ($urandom_range(0, 2) == 0) begin
               rand_vec(t_a); rand_vec(t_b);
               t_oper   = OW'($urandom);
               t_len    = ($urandom_range(0, 5) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(1, 8));
               t_scalar = 1'($urandom);
               t_valid  = 1'b1;
               pending  = 1'b1;
            end else begin
               t_valid = 1'b0;
            end
         end
         #1;
         exp_run = (exp_q.size() != 0);
         exp_tready = 1'b1;
         if (exp_run) exp_tready = exp_q[0].last && i_ready;
         n_checks++;
         if ({i_valid, busy, t_ready} !== {exp_run, exp_run, exp_tready})
            $display("FAIL rand_ctrl cyc%0d got v/busy/tr=%b want %b", cyc,
                     {i_valid, busy, t_ready}, {exp_run, exp_run, exp_tready});
         else n_pass++;
         if (exp_run) begin
            n_checks++;
            if ({i0_data, i1_data, i_oper, i_last} !== exp_q[0])
               $display("FAIL rand_beat cyc%0d got %h/%h/%h/%b want %h/%h/%h/%b", cyc,
                        i0_data, i1_data, i_oper, i_last, exp_q[0].a, exp_q[0].b, exp_q[0].oper, exp_q[0].last);
            else n_pass++;
            if (i_ready) void'(exp_q.pop_front());
         end
         if (t_valid && exp_tready) begin
            model_cmd(t_a, t_b, t_oper, t_len, t_scalar);
            pending = 1'b0;
         end
         @(negedge clk);
      end
      t_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_len_zero();
      test_len_clamp();
      test_reset_mid();
      test_scalar();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vector_lane_sequencer.md
# vector_lane_sequencer

Operand sequencer directly upstream of the vector ALU. It accepts one packed vector command: two operand vectors of LANES elements, an operation code and an element count. It then issues the elements one per cycle as scalar operand pairs over the ALU's valid/ready target interface. It decouples the wide register-file read from the single-lane ALU and marks the final element of each vector.

## Interface
Parameters:
- DATA_WIDTH, 10, element width; must match the ALU.
- OPER_WIDTH, 10, opcode width; must match the ALU.
- LANES, 8, elements per packed vector; ≥2.
- LEN_WIDTH, $clog2(LANES+1), width of the element-count field.

Ports. One clock; reset is asynchronous and active-low.
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- t_a, in, LANES*DATA_WIDTH, operand vector A; element k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- t_b, in, LANES*DATA_WIDTH, operand vector B; same packing as t_a.
- t_oper, in, OPER_WIDTH, opcode; carried unchanged to i_oper.
- t_len, in, LEN_WIDTH, number of elements to issue.
- t_scalar, in, 1, broadcast B element 0; used only when the configuration macro is defined.
- t_valid, in, 1, command valid.
- t_ready, out, 1, command accepted when t_valid && t_ready.
- i0_data, out, DATA_WIDTH, A element; drives the ALU t0_data.
- i1_data, out, DATA_WIDTH, B element; drives the ALU t1_data.
- i_oper, out, OPER_WIDTH, latched opcode.
- i_last, out, 1, high on the final element of the current command.
- i_valid, out, 1, element valid.
- i_ready, in, 1, ALU ready.
- busy, out, 1, high while a command is being issued.

## Operation
- FSM states: IDLE and RUN.
- In IDLE:
  - t_ready=1.
  - On a command handshake with t_len≥1: latch A, B, oper and len, set idx=0, go to RUN.
  - t_len=0: the command is accepted and dropped; no element is issued and the FSM stays in IDLE.
  - t_len>LANES: len is clamped to LANES.
- In RUN:
  - i_valid=1.
  - i0_data=A[idx] and i1_data=B[idx].
  - i_last=(idx==len-1).
  - On an i_valid && i_ready handshake with i_last=0: idx increments.
  - On a handshake with i_last=1: the command is complete.
- Back-to-back commands: in RUN, t_ready = i_last && i_ready (combinational).
  - A new command accepted in the same cycle as the last-element handshake keeps the FSM in RUN with idx=0 and the new operands.
  - A new command with t_len=0 in that cycle is dropped and the FSM goes to IDLE.
  - Without a new command, the FSM goes to IDLE.
- Stall: while i_valid && !i_ready, all i_* outputs hold stable.
- busy = (state==RUN).
- Reset:
  - rstn low forces state=IDLE, idx=0, latched vectors, oper and len to 0, i_valid=0, i_last=0, busy=0.
  - t_ready is gated to 0 while rstn is low.
  - Assertion mid-command aborts it immediately and asynchronously; the remaining elements are discarded.

## Timing
- Command accepted at edge N → element 0 is valid after edge N; the ALU can take it at edge N+1.
- Throughput is one element per cycle with i_ready held high. A len-L command occupies exactly L issue cycles, with no bubble between commands.
- i_valid, i_last, i_oper and the index are registered. i0_data/i1_data are a mux of registers by idx, with no input-to-output combinational path.
- t_ready is the only combinational output. It depends on state, i_last and i_ready.

## Configuration
- Macro: VECTOR_SEQ_SCALAR_EN.
- Defined: when the latched t_scalar=1, i1_data = B[0] for every element (vector-scalar operations). i0_data is unaffected.
- Undefined: the t_scalar port exists but is ignored; i1_data is always B[idx]. No scalar flag register is built.

## Structure
- The shared package vector_pkg holds:
  - the opcode enum (ADD=1, SUB=2, AND=3, OR=4, XOR=5, MV=6, ROL=7, ROR=8), shared with the ALU;
  - the default DATA_WIDTH, OPER_WIDTH and LANES constants;
  - the FSM state typedef.
- Sub-module vector_lane_mux: a combinational LANES:1 element selector, instantiated twice (for A and B).

## Test plan
- Single command: A={8,7,...,1}, B all 2, oper=ADD, len=8, i_ready=1 → eight beats (1,2)…(8,2) on consecutive cycles, i_oper=1, i_last only on the 8th beat.
- Backpressure: len=3, i_ready toggled 1,0,0,1,1 → beats 0,1,2 each held stable while stalled; exactly 3 handshakes, none duplicated.
- Back-to-back: two len=2 commands with t_valid held high → 4 consecutive beats with no idle cycle; t_ready pulses only with each last-beat handshake.
- Boundaries:
  - len=0 → accepted, no i_valid, stays in IDLE.
  - len=12 with LANES=8 → exactly 8 beats.
- Reset mid-operation: rstn dropped after beat 2 of len=8 → i_valid, busy and t_ready are 0 immediately. After release, a new len=1 command issues correctly at idx 0.
- Scalar mode (with VECTOR_SEQ_SCALAR_EN): B={…,9,5}, t_scalar=1, len=4 → i1_data=5 on all four beats. With the macro undefined → i1_data=B[idx].
